obi_mem_arbiter: RTL and testbench

Two-master OBI arbiter that shares one single-port `simple_mem` slave between an instruction requester (`m0`) and a data requester (`m1`). One example is a unified code and data RAM behind the CV32E40P core. It selects one request per cycle and holds that selection stable while a request is stalled. It records the issuing master of every accepted transfer in an in-order routing FIFO and returns each `rvalid`/`rdata` to the master that issued it.

---
 rtl/obi_mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_obi_mem_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/obi_mem_arbiter.sv
// rtl/obi_mem_arbiter.sv - two-master OBI arbiter with in-order response routing (tie-break option: OBI_ARB_RR_EN)
module obi_mem_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_req,
  output logic                m0_gnt,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic                m0_we,
  input  logic [DATA_W/8-1:0] m0_be,
  input  logic [DATA_W-1:0]   m0_wdata,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req,
  output logic                m1_gnt,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic                m1_we,
  input  logic [DATA_W/8-1:0] m1_be,
  input  logic [DATA_W-1:0]   m1_wdata,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                s_req,
  input  logic                s_gnt,
  output logic [ADDR_W-1:0]   s_addr,
  output logic                s_we,
  output logic [DATA_W/8-1:0] s_be,
  output logic [DATA_W-1:0]   s_wdata,
  input  logic                s_rvalid,
  input  logic [DATA_W-1:0]   s_rdata,
  output logic                err
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic             r_fifo [0:MAX_OUTSTANDING-1];
  logic             r_lock;
  logic             r_lock_id;
  logic             r_err;
`ifdef OBI_ARB_RR_EN
  logic             r_last_id;
`endif

  logic w_winner;
  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_head;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_head  = r_fifo[r_rptr];

  // Winner: a stalled request keeps its master; otherwise single requester or tie-break
  always_comb begin
    w_winner = 1'b0;
    if (r_lock) begin
      w_winner = r_lock_id;
    end else if (m0_req && m1_req) begin
`ifdef OBI_ARB_RR_EN
      w_winner = ~r_last_id;
`else
      w_winner = 1'b1;
`endif
    end else if (m1_req) begin
      w_winner = 1'b1;
    end
  end

  // Request path: slave fields follow the winner, blocked while the routing FIFO is full
  always_comb begin
    s_req   = (m0_req | m1_req) & ~w_full;
    s_addr  = w_winner ? m1_addr  : m0_addr;
    s_we    = w_winner ? m1_we    : m0_we;
    s_be    = w_winner ? m1_be    : m0_be;
    s_wdata = w_winner ? m1_wdata : m0_wdata;
    m0_gnt  = s_req & s_gnt & ~w_winner;
    m1_gnt  = s_req & s_gnt & w_winner;
  end

  assign w_push = s_req & s_gnt;
  assign w_pop  = s_rvalid & ~w_empty;

  // Response path: data is broadcast, only rvalid is steered by the FIFO head
  always_comb begin
    m0_rvalid = w_pop & ~w_head;
    m1_rvalid = w_pop & w_head;
    m0_rdata  = s_rdata;
    m1_rdata  = s_rdata;
    err       = r_err;
  end

  // Lock holds the winner stable from a stalled request until it is granted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lock    <= 1'b0;
      r_lock_id <= 1'b0;
    end else if (s_req && !s_gnt) begin
      r_lock    <= 1'b1;
      r_lock_id <= w_winner;
    end else if (w_push) begin
      r_lock    <= 1'b0;
    end
  end

  // Routing FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      if (w_push) r_wptr <= (r_wptr == LAST_PTR) ? '0 : r_wptr + 1'b1;
      if (w_pop)  r_rptr <= (r_rptr == LAST_PTR) ? '0 : r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  // Routing FIFO storage: contents are only meaningful below the occupancy count
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr] <= w_winner;
  end

  // Sticky error on a response with nothing outstanding
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       r_err <= 1'b0;
    else if (s_rvalid && w_empty)  r_err <= 1'b1;
  end

`ifdef OBI_ARB_RR_EN
  // Remember the last granted master for round-robin tie-breaks
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_last_id <= 1'b1;
    else if (w_push) r_last_id <= w_winner;
  end
`endif

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// tb/tb_obi_mem_arbiter.sv - directed self-checking bench for obi_mem_arbiter
module tb_obi_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m1_req, m0_gnt, m1_gnt;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_we, m1_we;
  logic [3:0]  m0_be, m1_be;
  logic        m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_req, s_gnt, s_we, s_rvalid;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_be;
  logic        err;

  logic        hold, force_rv;
  logic [31:0] rq [0:7];
  logic [3:0]  wr_p, rd_p;
  logic        slv_rv;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  obi_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_gnt(m0_gnt), .m0_addr(m0_addr), .m0_we(m0_we), .m0_be(m0_be),
    .m0_wdata(m0_wdata), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_gnt(m1_gnt), .m1_addr(m1_addr), .m1_we(m1_we), .m1_be(m1_be),
    .m1_wdata(m1_wdata), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .s_req(s_req), .s_gnt(s_gnt), .s_addr(s_addr), .s_we(s_we), .s_be(s_be),
    .s_wdata(s_wdata), .s_rvalid(s_rvalid), .s_rdata(s_rdata), .err(err)
  );

  function automatic logic [31:0] rsp(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // 1-cycle slave with an in-order response queue; hold withholds responses
  assign slv_rv   = ~hold & (wr_p != rd_p);
  assign s_rvalid = slv_rv | force_rv;
  assign s_rdata  = rq[rd_p[2:0]];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_p <= '0;
      rd_p <= '0;
    end else begin
      if (slv_rv) rd_p <= rd_p + 1'b1;
      if (s_req && s_gnt) begin
        rq[wr_p[2:0]] <= rsp(s_addr);
        wr_p <= wr_p + 1'b1;
      end
    end
  end

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b1; m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; m0_req = 0; m1_req = 0; m0_addr = 0; m1_addr = 0; m0_we = 0; m1_we = 0;
    m0_be = 4'hF; m1_be = 4'hF; m0_wdata = 0; m1_wdata = 0; s_gnt = 0; hold = 0; force_rv = 0;
    @(negedge clk); #1;
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL rst_s_req got %b exp 0", s_req); end
    checks++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin errors++; $display("FAIL rst_gnt got %b%b exp 00", m0_gnt, m1_gnt); end
    checks++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %b%b exp 00", m0_rvalid, m1_rvalid); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", err); end
    @(negedge clk); m0_req = 1'b1; m0_addr = 32'h44; s_gnt = 1'b1; #1;
    checks++; if (s_req !== 1'b1) begin errors++; $display("FAIL rst_passthru_req got %b exp 1", s_req); end
    checks++; if (s_addr !== 32'h44) begin errors++; $display("FAIL rst_passthru_addr got %h exp 00000044", s_addr); end
    @(negedge clk); m0_req = 1'b0; rst = 1'b0; #1;
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL rst_idle_req got %b exp 0", s_req); end
  endtask

  task automatic test_single_master();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      m0_req = (i < 3); m0_addr = 32'(i * 4); s_gnt = 1'b1; #1;
      checks++; if (m0_gnt !== (i < 3)) begin errors++; $display("FAIL single_gnt%0d got %b exp %b", i, m0_gnt, (i < 3)); end
      checks++; if (m0_rvalid !== (i >= 1 && i <= 3)) begin errors++; $display("FAIL single_rvalid%0d got %b exp %b", i, m0_rvalid, (i >= 1 && i <= 3)); end
      checks++; if (m1_rvalid !== 1'b0) begin errors++; $display("FAIL single_m1_rvalid%0d got %b exp 0", i, m1_rvalid); end
      if (i >= 1 && i <= 3) begin
        checks++; if (m0_rdata !== rsp(32'((i - 1) * 4))) begin errors++; $display("FAIL single_rdata%0d got %h exp %h", i, m0_rdata, rsp(32'((i - 1) * 4))); end
      end
    end
  endtask

  task automatic test_tie();
    logic exp_w [0:3];
    logic [31:0] pa;
`ifdef OBI_ARB_RR_EN
    exp_w[0] = 0; exp_w[1] = 1; exp_w[2] = 0; exp_w[3] = 1;
`else
    exp_w[0] = 1; exp_w[1] = 1; exp_w[2] = 1; exp_w[3] = 1;
`endif
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      m0_req = (i < 4); m1_req = (i < 4); s_gnt = 1'b1;
      m0_addr = 32'h100 + 32'(i * 4); m1_addr = 32'h200 + 32'(i * 4); #1;
      if (i < 4) begin
        checks++; if (m0_gnt !== ~exp_w[i] || m1_gnt !== exp_w[i]) begin errors++; $display("FAIL tie_gnt%0d got %b%b exp %b%b", i, m1_gnt, m0_gnt, exp_w[i], ~exp_w[i]); end
      end
      if (i > 0) begin
        pa = exp_w[i-1] ? 32'h200 + 32'((i - 1) * 4) : 32'h100 + 32'((i - 1) * 4);
        checks++; if (m0_rvalid !== ~exp_w[i-1] || m1_rvalid !== exp_w[i-1]) begin errors++; $display("FAIL tie_rvalid%0d got %b%b exp %b%b", i, m1_rvalid, m0_rvalid, exp_w[i-1], ~exp_w[i-1]); end
        checks++; if (m0_rdata !== rsp(pa)) begin errors++; $display("FAIL tie_rdata%0d got %h exp %h", i, m0_rdata, rsp(pa)); end
      end
    end
  endtask

  task automatic test_lock();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      m0_req = 1'b1; m0_addr = 32'hA00; s_gnt = 1'b0;
      m1_req = (i >= 1); m1_addr = 32'hB00; #1;
      checks++; if (s_addr !== 32'hA00) begin errors++; $display("FAIL lock_addr%0d got %h exp 00000a00", i, s_addr); end
      checks++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin errors++; $display("FAIL lock_nogrant%0d got %b%b exp 00", i, m1_gnt, m0_gnt); end
    end
    @(negedge clk); s_gnt = 1'b1; #1;
    checks++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin errors++; $display("FAIL lock_first got %b%b exp 01", m1_gnt, m0_gnt); end
    checks++; if (s_addr !== 32'hA00) begin errors++; $display("FAIL lock_first_addr got %h exp 00000a00", s_addr); end
    @(negedge clk); m0_req = 1'b0; #1;
    checks++; if (m1_gnt !== 1'b1 || s_addr !== 32'hB00) begin errors++; $display("FAIL lock_second got gnt %b addr %h exp 1 00000b00", m1_gnt, s_addr); end
    checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== rsp(32'hA00)) begin errors++; $display("FAIL lock_rsp0 got %b %h exp 1 %h", m0_rvalid, m0_rdata, rsp(32'hA00)); end
    @(negedge clk); m1_req = 1'b0; #1;
    checks++; if (m1_rvalid !== 1'b1 || m1_rdata !== rsp(32'hB00)) begin errors++; $display("FAIL lock_rsp1 got %b %h exp 1 %h", m1_rvalid, m1_rdata, rsp(32'hB00)); end
  endtask

  task automatic test_full();
    @(negedge clk); hold = 1'b1; m0_req = 1'b1; m0_addr = 32'h300; s_gnt = 1'b1; #1;
    checks++; if (m0_gnt !== 1'b1) begin errors++; $display("FAIL full_g0 got %b exp 1", m0_gnt); end
    @(negedge clk); m0_req = 1'b0; m1_req = 1'b1; m1_addr = 32'h304; #1;
    checks++; if (m1_gnt !== 1'b1) begin errors++; $display("FAIL full_g1 got %b exp 1", m1_gnt); end
    checks++; if (m0_rvalid !== 1'b0) begin errors++; $display("FAIL full_held got %b exp 0", m0_rvalid); end
    @(negedge clk); m1_req = 1'b0; m0_req = 1'b1; m0_addr = 32'h308; #1;
    checks++; if (s_req !== 1'b0 || m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin errors++; $display("FAIL full_block got req %b gnt %b%b exp 0 00", s_req, m1_gnt, m0_gnt); end
    @(negedge clk); hold = 1'b0; #1;
    checks++; if (s_req !== 1'b0 || m0_gnt !== 1'b0) begin errors++; $display("FAIL full_block_pop got req %b gnt %b exp 0 0", s_req, m0_gnt); end
    checks++; if (m0_rvalid !== 1'b1 || m1_rvalid !== 1'b0 || m0_rdata !== rsp(32'h300)) begin errors++; $display("FAIL full_rsp0 got %b%b %h exp 01 %h", m1_rvalid, m0_rvalid, m0_rdata, rsp(32'h300)); end
    @(negedge clk); hold = 1'b1; #1;
    checks++; if (s_req !== 1'b1 || m0_gnt !== 1'b1) begin errors++; $display("FAIL full_reopen got req %b gnt %b exp 1 1", s_req, m0_gnt); end
    checks++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin errors++; $display("FAIL full_quiet got %b%b exp 00", m1_rvalid, m0_rvalid); end
    @(negedge clk); m0_req = 1'b0; hold = 1'b0; #1;
    checks++; if (m1_rvalid !== 1'b1 || m0_rvalid !== 1'b0 || m1_rdata !== rsp(32'h304)) begin errors++; $display("FAIL full_rsp1 got %b%b %h exp 10 %h", m1_rvalid, m0_rvalid, m1_rdata, rsp(32'h304)); end
    @(negedge clk); #1;
    checks++; if (m0_rvalid !== 1'b1 || m1_rvalid !== 1'b0 || m0_rdata !== rsp(32'h308)) begin errors++; $display("FAIL full_rsp2 got %b%b %h exp 01 %h", m1_rvalid, m0_rvalid, m0_rdata, rsp(32'h308)); end
    @(negedge clk); #1;
    checks++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin errors++; $display("FAIL full_drained got %b%b exp 00", m1_rvalid, m0_rvalid); end
  endtask

  task automatic test_error();
    @(negedge clk); force_rv = 1'b1; #1;
    checks++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin errors++; $display("FAIL err_rvalid got %b%b exp 00", m1_rvalid, m0_rvalid); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_early got %b exp 0", err); end
    @(negedge clk); force_rv = 1'b0; #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set got %b exp 1", err); end
    @(negedge clk); #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", err); end
    @(negedge clk); rst = 1'b1; #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear got %b exp 0", err); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic exp_w;
`ifdef OBI_ARB_RR_EN
    exp_w = 1'b0;
`else
    exp_w = 1'b1;
`endif
    @(negedge clk); hold = 1'b1; m0_req = 1'b1; m0_addr = 32'h400; s_gnt = 1'b1; #1;
    checks++; if (m0_gnt !== 1'b1) begin errors++; $display("FAIL mid_grant got %b exp 1", m0_gnt); end
    @(negedge clk); m0_req = 1'b0; m1_req = 1'b1; m1_addr = 32'h404; s_gnt = 1'b0; #1;
    checks++; if (s_req !== 1'b1 || m1_gnt !== 1'b0) begin errors++; $display("FAIL mid_stall got req %b gnt %b exp 1 0", s_req, m1_gnt); end
    @(negedge clk); #1;
    checks++; if (dut.r_count !== 2'd1 || dut.r_lock !== 1'b1) begin errors++; $display("FAIL mid_pre got count %0d lock %b exp 1 1", dut.r_count, dut.r_lock); end
    rst = 1'b1; #1;
    checks++; if (dut.r_count !== 2'd0 || dut.r_lock !== 1'b0) begin errors++; $display("FAIL mid_async got count %0d lock %b exp 0 0", dut.r_count, dut.r_lock); end
    @(negedge clk); m1_req = 1'b0;
    @(negedge clk); rst = 1'b0; hold = 1'b0; m0_req = 1'b1; m1_req = 1'b1;
    m0_addr = 32'h410; m1_addr = 32'h414; s_gnt = 1'b1; #1;
    checks++; if (m0_gnt !== ~exp_w || m1_gnt !== exp_w) begin errors++; $display("FAIL mid_tie got %b%b exp %b%b", m1_gnt, m0_gnt, exp_w, ~exp_w); end
    @(negedge clk); m0_req = 1'b0; m1_req = 1'b0; #1;
    checks++; if (m0_rvalid !== ~exp_w || m1_rvalid !== exp_w) begin errors++; $display("FAIL mid_rsp got %b%b exp %b%b", m1_rvalid, m0_rvalid, exp_w, ~exp_w); end
    checks++; if (m0_rdata !== rsp(exp_w ? 32'h414 : 32'h410)) begin errors++; $display("FAIL mid_rdata got %h exp %h", m0_rdata, rsp(exp_w ? 32'h414 : 32'h410)); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL mid_err got %b exp 0", err); end
  endtask

  initial begin
    test_reset();
    test_single_master();
    test_tie();
    test_lock();
    test_full();
    test_error();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
